wb_spim: RTL and testbench
==========================

Name: wb_spim

Overview:
Wishbone classic slave peripheral that acts as an SPI master. It sits behind buscon as a new address-decoded slave alongside gio and bram. It lets the SERV CPU, or the SPI-slave bridge, drive an external SPI device. It is the master-side counterpart of the existing SPI-slave-to-Wishbone bridge: mode 0, MSB first, 8-bit transfers, with software-controlled chip select.

Parameters:
DEFAULT_DIV, 8'd3, reset value of the DIV register; one SCLK half-period lasts (DIV+1) wb_clk cycles.

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  asynchronous, active-high reset
wb_cyc  in  1  Wishbone cycle
wb_stb  in  1  Wishbone strobe (already address-decoded by buscon)
wb_we  in  1  write enable
wb_sel  in  4  byte selects
wb_adr  in  8  word address; only bits [3:2] are decoded
wb_dat  in  32  write data
wb_rdt  out  32  read data
wb_ack  out  1  acknowledge
spi_csn  out  1  chip select, active low
spi_clk  out  1  SCLK
spi_mosi  out  1  master out
spi_miso  in  1  master in; assumed synchronous to wb_clk (external device clocked by spi_clk)

Behaviour:
- Reset (async, wb_rst=1) forces: state IDLE, spi_clk=0, spi_csn=1, spi_mosi=0, wb_ack=0, wb_rdt=0, cs=0, rx=0, done=0, ovr=0, DIV=DEFAULT_DIV.
- Reset asserted mid-transfer aborts immediately. No done flag is set.
- Bus handshake:
  - ack <= !ack && cyc && stb, giving exactly one wait state.
  - An access is "accepted" on the edge where ack rises. Writes commit on that edge; wb_rdt is registered on that edge.
  - Back-to-back strobes produce alternating ack.
- Register map by wb_adr[3:2]:
  - 0 DATA: write sel[0] -> tx byte, starts a transfer. Read -> {24'h0, rx}; the read clears done.
  - 1 CTRL:
    - bit0 cs: RW, sel[0]; spi_csn = ~cs.
    - bit8 busy: RO.
    - bit9 done: RO, sticky.
    - bit10 ovr: sticky; cleared by writing 1 with sel[1].
  - 2 DIV: bits[7:0] RW, sel[0].
  - 3: reads 0, writes ignored.
  - Unselected bytes are unchanged.
- Transfer start:
  - A DATA write accepted while busy=0 loads the shifter, sets busy on the same edge, and drives spi_mosi=tx[7].
  - A DATA write accepted while busy=1 is dropped and sets ovr.
  - busy is the registered value, so a write on the exact edge a transfer finishes counts as overrun.
- Serial engine: 16 half-periods, phase 0..15, each (DIV+1) cycles.
  - Even phase: spi_clk=0. Odd phase: spi_clk=1.
  - Entering an odd phase (rising edge): sample spi_miso into rx shift LSB.
  - Leaving an odd phase (falling edge): shift tx left, spi_mosi = next bit.
  - After phase 15: spi_clk=0, rx register updated with the full byte, busy=0, done=1.
  - busy is high for exactly 16*(DIV+1) cycles.
- Simultaneous events:
  - done set and DATA-read clear on the same edge: set wins.
  - DIV written during a transfer takes effect at the next half-period boundary.
- DATA read while busy returns the previous rx byte.
- spi_csn is independent of busy. Software holds cs across multi-byte frames.
- DIV=0 gives SCLK = wb_clk/2.

Decomposition:
- Shared package/header wb_spim_defs:
  - register offsets REG_DATA=0, REG_CTRL=1, REG_DIV=2;
  - CTRL bit positions CS=0, BUSY=8, DONE=9, OVR=10;
  - phase count constant 16.
- One sub-module, spim_shifter: divider counter, phase counter, tx/rx shift registers.
  - Inputs: start, tx[7:0], div[7:0], miso.
  - Outputs: busy, done_pulse, rx[7:0], sclk, mosi.
  - It uses the same clock and async reset.
- wb_spim holds the bus logic and registers.

Test Plan:
1. Reset, then read CTRL=0x0000_0000, DIV=0x03; pins show csn=1, clk=0, mosi=0.
2. Write CTRL=1, DIV=0, DATA=0xA5 with miso looped to mosi:
   - spi_mosi shows 1,0,1,0,0,1,0,1 on rising edges;
   - busy high for 16 cycles;
   - DATA then reads 0xA5 and CTRL reads 0x201;
   - a second CTRL read returns 0x001 (done cleared).
3. DIV=3, DATA=0x3C, miso tied 1:
   - each SCLK half-period is 4 cycles;
   - transfer lasts 64 cycles;
   - rx=0xFF.
4. DATA=0x12, then DATA=0x34 while busy:
   - the second write is ignored (only 8 SCLK pulses, mosi pattern of 0x12);
   - CTRL bit10=1;
   - writing CTRL=0x0000_0401 with sel=4'b0011 clears ovr and keeps cs=1.
5. Assert wb_rst at phase 7 of a transfer:
   - outputs return to reset values asynchronously, before the next clock edge;
   - after release, busy=0, done=0, and a new transfer completes normally.
6. Bus protocol: hold cyc/stb high for 4 cycles and observe ack=0,1,0,1. A write with sel=4'b0000 to DIV leaves DIV unchanged.

Source files
------------

// File: rtl/wb_spim_pkg.sv
// wb_spim_pkg: register map, CTRL bit positions and serial engine constants for wb_spim
package wb_spim_pkg;
  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_CTRL = 2'd1,
    REG_DIV  = 2'd2,
    REG_NONE = 2'd3
  } reg_e;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;
  localparam int CTRL_CS = 0;
  localparam int CTRL_BUSY = 8;
  localparam int CTRL_DONE = 9;
  localparam int CTRL_OVR = 10;
  localparam int PHASES = 16;
  function automatic logic [31:0] ctrl_word(input logic cs, input logic busy, input logic done,
                                            input logic ovr);
    ctrl_word = '0;
    ctrl_word[CTRL_CS] = cs;
    ctrl_word[CTRL_BUSY] = busy;
    ctrl_word[CTRL_DONE] = done;
    ctrl_word[CTRL_OVR] = ovr;
  endfunction
endpackage

// File: rtl/wb_spim_shifter.sv
// spim_shifter: mode-0 MSB-first 8-bit SPI engine with per-half-period divider
module spim_shifter
  import wb_spim_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] rx,
  output logic       sclk,
  output logic       mosi
);
  state_e state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d, div_q, div_d, tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, last;
  // half-period sequencing: sample on entering odd phases, shift on leaving them
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    div_d = div_q;
    tx_d = tx_q;
    sh_d = sh_q;
    rx_d = rx_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    last = state_q == S_XFER && cnt_q == div_q && phase_q == 4'(PHASES - 1);
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_XFER;
        phase_d = '0;
        cnt_d = '0;
        div_d = div;
        tx_d = tx;
        mosi_d = tx[7];
        sclk_d = 1'b0;
      end
    end else if (cnt_q != div_q) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = '0;
      div_d = div;
      phase_d = phase_q + 4'd1;
      if (!phase_q[0]) begin
        sclk_d = 1'b1;
        sh_d = {sh_q[6:0], miso};
      end else begin
        sclk_d = 1'b0;
        tx_d = {tx_q[6:0], 1'b0};
        mosi_d = tx_q[6];
      end
      if (last) begin
        state_d = S_IDLE;
        rx_d = sh_q;
      end
    end
  end
  // engine state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q <= '0;
      div_q <= '0;
      tx_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      tx_q <= tx_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end
  assign busy = state_q == S_XFER;
  assign done_pulse = last;
  assign rx = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
endmodule

// File: rtl/wb_spim.sv
// wb_spim: Wishbone classic slave exposing an SPI master with DATA/CTRL/DIV registers
module wb_spim
  import wb_spim_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [7:0]  wb_adr,
  input  logic [31:0] wb_dat,
  output logic [31:0] wb_rdt,
  output logic        wb_ack,
  output logic        spi_csn,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  logic ack_q, ack_d, cs_q, cs_d, done_q, done_d, ovr_q, ovr_d;
  logic [7:0] div_q, div_d, rx;
  logic [31:0] rdt_q, rdt_d;
  logic wr, rd, start, busy, done_pulse, unused_bits;
  reg_e a;
  // bus decode; an access is accepted on the edge where ack rises
  always_comb begin
    a = reg_e'(wb_adr[3:2]);
    ack_d = !ack_q && wb_cyc && wb_stb;
    wr = ack_d && wb_we;
    rd = ack_d && !wb_we;
    start = wr && a == REG_DATA && wb_sel[0];
    cs_d = wr && a == REG_CTRL && wb_sel[0] ? wb_dat[CTRL_CS] : cs_q;
    div_d = wr && a == REG_DIV && wb_sel[0] ? wb_dat[7:0] : div_q;
    ovr_d = start && busy ? 1'b1 :
            wr && a == REG_CTRL && wb_sel[1] && wb_dat[CTRL_OVR] ? 1'b0 : ovr_q;
    done_d = done_pulse ? 1'b1 : rd && a == REG_DATA ? 1'b0 : done_q;
    rdt_d = !rd ? rdt_q :
            a == REG_DATA ? {24'h0, rx} :
            a == REG_CTRL ? ctrl_word(cs_q, busy, done_q, ovr_q) :
            a == REG_DIV ? {24'h0, div_q} : '0;
  end
  // bus-side registers
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ack_q <= 1'b0;
      cs_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      div_q <= DEFAULT_DIV;
      rdt_q <= '0;
    end else begin
      ack_q <= ack_d;
      cs_q <= cs_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
      div_q <= div_d;
      rdt_q <= rdt_d;
    end
  end
  spim_shifter u_shifter (
    .clk(wb_clk),
    .rst(wb_rst),
    .start(start),
    .tx(wb_dat[7:0]),
    .div(div_q),
    .miso(spi_miso),
    .busy(busy),
    .done_pulse(done_pulse),
    .rx(rx),
    .sclk(spi_clk),
    .mosi(spi_mosi)
  );
  assign unused_bits = ^{wb_adr[7:4], wb_adr[1:0], wb_sel[3:2], wb_dat[31:11], wb_dat[9:8]};
  assign wb_ack = ack_q;
  assign wb_rdt = rdt_q;
  assign spi_csn = ~cs_q;
endmodule

// File: tb/tb_wb_spim.sv
// tb_wb_spim: randomized scoreboard bench for wb_spim with an edge-indexed reference model
module tb_wb_spim;
  logic wb_clk = 0, wb_rst = 1, wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [3:0] wb_sel = '0;
  logic [7:0] wb_adr = '0;
  logic [31:0] wb_dat = '0, wb_rdt;
  logic wb_ack, spi_csn, spi_clk, spi_mosi, spi_miso;
  logic inv = 0, tie = 0;
  int checks = 0, errors = 0, cyc_n = 0;
  typedef struct {
    int   edge_n;
    logic rise;
    logic bit_v;
  } pin_t;
  pin_t pin_q[$];
  logic [31:0] rd_q[$];
  int s_edge = -1000, s_len = 0, f_prev = -1, last_rd = -1;
  logic [7:0] rx_cur = 0, rx_prev = 0, m_div = 8'd3;
  logic m_cs = 0, m_ovr = 0;
  logic prev_clk = 0;

  wb_spim dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_rdt(wb_rdt), .wb_ack(wb_ack),
    .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  assign spi_miso = tie | (spi_mosi ^ inv);
  always #5 wb_clk = ~wb_clk;
  always @(posedge wb_clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // A transfer started at edge S occupies edges S+1 .. S+len; it completes on edge S+len.
  function automatic bit active(input int e);
    return e > s_edge && e <= s_edge + s_len;
  endfunction

  function automatic bit completed(input int e);
    return s_len > 0 && e > s_edge + s_len;
  endfunction

  function automatic logic [7:0] rx_at(input int e);
    return completed(e) ? rx_cur : rx_prev;
  endfunction

  function automatic bit done_at(input int e);
    int f;
    f = completed(e) ? s_edge + s_len : f_prev;
    return f >= 0 && last_rd <= f;
  endfunction

  function automatic void model_rd(input int e, input logic [1:0] a);
    logic [31:0] v;
    v = a == 2'd0 ? {24'h0, rx_at(e)} :
        a == 2'd1 ? {21'h0, m_ovr, done_at(e), active(e), 7'h0, m_cs} :
        a == 2'd2 ? {24'h0, m_div} : 32'h0;
    if (a == 2'd0) last_rd = e;
    rd_q.push_back(v);
  endfunction

  function automatic void model_wr(input int e, input logic [1:0] a, input logic [31:0] d,
                                   input logic [3:0] sel);
    int h;
    if (a == 2'd0 && sel[0]) begin
      if (active(e)) m_ovr = 1;
      else begin
        if (s_len > 0) begin
          f_prev = s_edge + s_len;
          rx_prev = rx_cur;
        end
        h = m_div + 1;
        s_edge = e;
        s_len = 16 * h;
        rx_cur = tie ? 8'hFF : d[7:0] ^ {8{inv}};
        for (int i = 0; i < 8; i++) begin
          pin_q.push_back('{e + (2 * i + 1) * h, 1'b1, d[7-i]});
          pin_q.push_back('{e + (2 * i + 2) * h, 1'b0, 1'b0});
        end
      end
    end
    if (a == 2'd1 && sel[0]) m_cs = d[0];
    if (a == 2'd1 && sel[1] && d[10]) m_ovr = 0;
    if (a == 2'd2 && sel[0]) m_div = d[7:0];
  endfunction

  function automatic void model_reset();
    s_edge = -1000;
    s_len = 0;
    f_prev = -1;
    last_rd = -1;
    rx_cur = 0;
    rx_prev = 0;
    m_div = 8'd3;
    m_cs = 0;
    m_ovr = 0;
    pin_q.delete();
  endfunction

  // Called at a negedge; the access is accepted on the following posedge.
  task automatic access(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] sel);
    int e, k;
    @(negedge wb_clk);
    e = cyc_n + 1;
    if (we) model_wr(e, a, d, sel);
    else model_rd(e, a);
    wb_cyc = 1;
    wb_stb = 1;
    wb_we = we;
    wb_adr = {4'h0, a, 2'b00};
    wb_dat = d;
    wb_sel = sel;
    k = 0;
    do begin
      @(negedge wb_clk);
      k++;
    end while (!wb_ack && k < 8);
    if (!wb_ack) chk("ack_timeout", 32'd0, 32'd1);
    wb_cyc = 0;
    wb_stb = 0;
    wb_we = 0;
  endtask

  task automatic wait_to(input int t);
    while (cyc_n < t - 2) @(negedge wb_clk);
  endtask

  task automatic wait_idle();
    while (cyc_n <= s_edge + s_len + 1) @(negedge wb_clk);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  // monitor: read data against the scoreboard, SCLK edges against the expected pin schedule
  always begin
    pin_t p;
    logic [31:0] v;
    @(posedge wb_clk);
    #1;
    if (wb_ack && !wb_we) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        v = rd_q.pop_front();
        chk("rd_data", wb_rdt, v);
      end
    end
    if (wb_rst) prev_clk = spi_clk;
    else if (spi_clk != prev_clk) begin
      prev_clk = spi_clk;
      if (pin_q.size() == 0) chk("sclk_unexpected", {31'h0, spi_clk}, 32'hFFFF_FFFF);
      else begin
        p = pin_q.pop_front();
        chk("sclk_edge", {cyc_n[29:0], spi_clk, spi_clk & spi_mosi},
            {p.edge_n[29:0], p.rise, p.bit_v});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    errors++;
    summary();
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tx;
    repeat (3) @(negedge wb_clk);
    wb_rst = 0;
    chk("rst_csn", {31'h0, spi_csn}, 32'd1);
    chk("rst_sclk", {31'h0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'h0, spi_mosi}, 32'd0);
    chk("rst_ack", {31'h0, wb_ack}, 32'd0);
    chk("rst_rdt", wb_rdt, 32'd0);
    access(0, 2'd1, 0, 4'hF);
    access(0, 2'd2, 0, 4'hF);
    // loopback A5 at DIV=0
    access(1, 2'd1, 32'h1, 4'h1);
    access(1, 2'd2, 32'h0, 4'h1);
    access(1, 2'd0, 32'hA5, 4'h1);
    access(0, 2'd1, 0, 4'hF);
    wait_idle();
    access(0, 2'd1, 0, 4'hF);
    access(0, 2'd0, 0, 4'hF);
    access(0, 2'd1, 0, 4'hF);
    chk("cs_pin", {31'h0, spi_csn}, 32'd0);
    // miso tied high at DIV=3; DATA read on the completion edge: done set wins
    access(1, 2'd2, 32'h3, 4'h1);
    tie = 1;
    access(1, 2'd0, 32'h3C, 4'h1);
    access(0, 2'd1, 0, 4'hF);
    wait_to(s_edge + s_len);
    access(0, 2'd0, 0, 4'hF);
    access(0, 2'd1, 0, 4'hF);
    access(0, 2'd0, 0, 4'hF);
    tie = 0;
    // overrun while busy, ovr clear with cs kept, overrun on the exact completion edge
    access(1, 2'd0, 32'h12, 4'h1);
    access(1, 2'd0, 32'h34, 4'h1);
    access(0, 2'd1, 0, 4'hF);
    access(1, 2'd1, 32'h401, 4'h3);
    access(0, 2'd1, 0, 4'hF);
    wait_to(s_edge + s_len);
    access(1, 2'd0, 32'h77, 4'h1);
    wait_idle();
    access(0, 2'd1, 0, 4'hF);
    access(0, 2'd0, 0, 4'hF);
    access(1, 2'd1, 32'h401, 4'h3);
    // reset in phase 7
    access(1, 2'd0, 32'h96, 4'h1);
    access(0, 2'd2, 0, 4'hF);
    while (cyc_n < s_edge + 7 * (m_div + 1) + 1) @(negedge wb_clk);
    chk("pre_rst_sclk", {31'h0, spi_clk}, 32'd1);
    #2 wb_rst = 1;
    #1;
    chk("arst_csn", {31'h0, spi_csn}, 32'd1);
    chk("arst_sclk", {31'h0, spi_clk}, 32'd0);
    chk("arst_mosi", {31'h0, spi_mosi}, 32'd0);
    chk("arst_ack", {31'h0, wb_ack}, 32'd0);
    chk("arst_rdt", wb_rdt, 32'd0);
    model_reset();
    repeat (2) @(negedge wb_clk);
    wb_rst = 0;
    access(0, 2'd1, 0, 4'hF);
    access(0, 2'd2, 0, 4'hF);
    access(1, 2'd0, 32'h5A, 4'h1);
    wait_idle();
    access(0, 2'd0, 0, 4'hF);
    access(0, 2'd1, 0, 4'hF);
    // randomized transfers
    for (int n = 0; n < 8; n++) begin
      tx = 8'($urandom);
      inv = 1'($urandom_range(0, 1));
      access(1, 2'd1, {31'h0, 1'($urandom_range(0, 1))}, 4'h1);
      access(1, 2'd2, 32'($urandom_range(0, 3)), 4'h1);
      access(1, 2'd0, {24'h0, tx}, 4'h1);
      access(0, 2'd0, 0, 4'hF);
      access(0, 2'd1, 0, 4'hF);
      wait_idle();
      access(0, 2'd1, 0, 4'hF);
      access(0, 2'd0, 0, 4'hF);
    end
    inv = 0;
    // held strobe alternates ack; sel=0 write leaves DIV alone
    @(negedge wb_clk);
    model_rd(cyc_n + 1, 2'd2);
    model_rd(cyc_n + 3, 2'd2);
    wb_cyc = 1;
    wb_stb = 1;
    wb_we = 0;
    wb_adr = 8'h08;
    chk("ack_seq0", {31'h0, wb_ack}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge wb_clk);
      chk("ack_seq", {31'h0, wb_ack}, 32'(i % 2));
    end
    wb_cyc = 0;
    wb_stb = 0;
    access(1, 2'd2, 32'hAB, 4'h0);
    access(0, 2'd2, 0, 4'hF);
    access(0, 2'd3, 0, 4'hF);
    repeat (4) @(negedge wb_clk);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("pin_q_empty", 32'(pin_q.size()), 32'd0);
    summary();
    $finish;
  end
endmodule
